uart_tx_scheduler: RTL and testbench

- Shares the single UART transmitter between two sources: the receive echo path and a fixed "Hello world!\n" message generator.
- Sits between the receiver (`rx_word`/`rx_valid`) and the transmitter (`tx_word`/`tx_req`/`tx_done`).
- Replaces the ad-hoc echo/connection_status logic at the top level.
- Buffers echo bytes in a small FIFO so that nothing received during a message burst is lost.

---
 rtl/uart_tx_scheduler_if.sv | 27 ++
 rtl/uart_tx_scheduler.sv | 200 ++++++++++++++++++++
 tb/tb_uart_tx_scheduler.sv | 316 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_scheduler_if.sv
// Scheduler-side bundle: receiver input, transmitter handshake and status outputs.
// master = scheduler, slave = the environment around it (receiver, transmitter, switch).
interface uart_tx_scheduler_if #(
    parameter int unsigned FIFO_DEPTH = 4
);
    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

    logic          sw;
    logic [7:0]    rx_word;
    logic          rx_valid;
    logic          tx_done;
    logic [7:0]    tx_word;
    logic          tx_req;
    logic          msg_active;
    logic          overflow;
    logic [CW-1:0] fifo_count;

    modport master (
        input  sw, rx_word, rx_valid, tx_done,
        output tx_word, tx_req, msg_active, overflow, fifo_count
    );

    modport slave (
        output sw, rx_word, rx_valid, tx_done,
        input  tx_word, tx_req, msg_active, overflow, fifo_count
    );
endinterface

// File: rtl/uart_tx_scheduler.sv
// Shares one UART transmitter between a buffered receive-echo path and a
// repeating "Hello world!\n" generator; echo always wins when both are ready.
module uart_tx_scheduler #(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned GAP_CYCLES = 1000
) (
    input  logic                   clk,
    input  logic                   rst,
    uart_tx_scheduler_if.master    bus
);
    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam int unsigned GW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
    localparam logic [3:0]  MSG_LAST = 4'd12;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ECHO,
        S_MSG,
        S_MSG_NEXT
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;

    logic          r_rx_prev;
    logic [7:0]    r_mem [FIFO_DEPTH];
    logic [AW-1:0] r_rd_ptr;
    logic [AW-1:0] r_wr_ptr;
    logic [CW-1:0] r_count;
    logic          r_overflow;

    logic [7:0]    r_tx_word;
    logic          r_tx_req;
    logic          r_msg_active;
    logic [3:0]    r_idx;
    logic [GW-1:0] r_gap;

    logic          w_push;
    logic          w_full;
    logic          w_push_ok;
    logic          w_pop;
    logic          w_gap_load;
    logic [7:0]    w_tx_word_nxt;
    logic          w_tx_req_nxt;
    logic          w_msg_active_nxt;
    logic [3:0]    w_idx_nxt;

    function automatic logic [7:0] msg_rom(input logic [3:0] a);
        case (a)
            4'd0:    msg_rom = 8'h48;
            4'd1:    msg_rom = 8'h65;
            4'd2:    msg_rom = 8'h6C;
            4'd3:    msg_rom = 8'h6C;
            4'd4:    msg_rom = 8'h6F;
            4'd5:    msg_rom = 8'h20;
            4'd6:    msg_rom = 8'h77;
            4'd7:    msg_rom = 8'h6F;
            4'd8:    msg_rom = 8'h72;
            4'd9:    msg_rom = 8'h6C;
            4'd10:   msg_rom = 8'h64;
            4'd11:   msg_rom = 8'h21;
            4'd12:   msg_rom = 8'h0A;
            default: msg_rom = 8'h00;
        endcase
    endfunction

    // A byte is offered once per rising edge of the receiver's valid level.
    assign w_push    = bus.rx_valid & ~r_rx_prev;
    assign w_full    = (r_count == CW'(FIFO_DEPTH));
    assign w_push_ok = w_push & (~w_full | w_pop);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (r_count != '0)
                    w_state_nxt = S_ECHO;
                else if (bus.sw && (r_gap == '0))
                    w_state_nxt = S_MSG;
            end
            S_ECHO: begin
                if (bus.tx_done)
                    w_state_nxt = S_IDLE;
            end
            S_MSG: begin
                if (bus.tx_done)
                    w_state_nxt = (r_idx == MSG_LAST) ? S_IDLE : S_MSG_NEXT;
            end
            S_MSG_NEXT: w_state_nxt = S_MSG;
            default:    w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_tx_word_nxt    = r_tx_word;
        w_tx_req_nxt     = r_tx_req;
        w_msg_active_nxt = r_msg_active;
        w_idx_nxt        = r_idx;
        w_pop            = 1'b0;
        w_gap_load       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (r_count != '0) begin
                    w_pop         = 1'b1;
                    w_tx_word_nxt = r_mem[r_rd_ptr];
                    w_tx_req_nxt  = 1'b1;
                end else if (bus.sw && (r_gap == '0)) begin
                    w_tx_word_nxt    = msg_rom(4'd0);
                    w_tx_req_nxt     = 1'b1;
                    w_msg_active_nxt = 1'b1;
                    w_idx_nxt        = 4'd0;
                end
            end
            S_ECHO: begin
                if (bus.tx_done)
                    w_tx_req_nxt = 1'b0;
            end
            S_MSG: begin
                if (bus.tx_done) begin
                    w_tx_req_nxt = 1'b0;
                    if (r_idx == MSG_LAST) begin
                        w_msg_active_nxt = 1'b0;
                        w_gap_load       = 1'b1;
                    end else begin
                        w_idx_nxt = 4'(r_idx + 4'd1);
                    end
                end
            end
            S_MSG_NEXT: begin
                w_tx_word_nxt = msg_rom(r_idx);
                w_tx_req_nxt  = 1'b1;
            end
            default: ;
        endcase
    end

    // Transmit-side registers and the inter-message gap timer.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_tx_word    <= 8'h00;
            r_tx_req     <= 1'b0;
            r_msg_active <= 1'b0;
            r_idx        <= 4'd0;
            r_gap        <= '0;
        end else begin
            r_tx_word    <= w_tx_word_nxt;
            r_tx_req     <= w_tx_req_nxt;
            r_msg_active <= w_msg_active_nxt;
            r_idx        <= w_idx_nxt;
            if (w_gap_load)
                r_gap <= GW'(GAP_CYCLES);
            else if (r_gap != '0)
                r_gap <= r_gap - GW'(1);
        end
    end

    // Echo FIFO control; pointers wrap naturally since the depth is a power of two.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rx_prev  <= 1'b0;
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_rx_prev <= bus.rx_valid;
            if (w_push_ok)
                r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)
                r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_push_ok, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
            if (w_push && w_full && !w_pop)
                r_overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push_ok)
            r_mem[r_wr_ptr] <= bus.rx_word;
    end

    assign bus.tx_word    = r_tx_word;
    assign bus.tx_req     = r_tx_req;
    assign bus.msg_active = r_msg_active;
    assign bus.overflow   = r_overflow;
    assign bus.fifo_count = r_count;
endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Bench for uart_tx_scheduler: a transmitter model checks every byte it is
// asked to send against a scoreboard of expected bytes filled as stimulus is driven.
module tb_uart_tx_scheduler;
    localparam int unsigned DEPTH    = 4;
    localparam int unsigned GAP      = 30;
    localparam int unsigned DONE_DLY = 5;

    logic clk;
    logic rst;

    uart_tx_scheduler_if #(.FIFO_DEPTH(DEPTH)) bus ();

    uart_tx_scheduler #(
        .FIFO_DEPTH (DEPTH),
        .GAP_CYCLES (GAP)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int         n_checks;
    int         n_fail;
    int         n_rise;
    int         done_req;
    bit         auto_done;
    logic [7:0] sb [$];
    logic [7:0] rom [13];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic push_msg();
        foreach (rom[i]) sb.push_back(rom[i]);
    endtask

    task automatic rx_send(input logic [7:0] b, input bit expect_tx);
        @(negedge clk);
        bus.rx_word  = b;
        bus.rx_valid = 1'b1;
        if (expect_tx) sb.push_back(b);
        repeat (2) @(negedge clk);
        bus.rx_valid = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        sb.delete();
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic wait_idle(input string tag, input int budget);
        bit ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk); #1;
            if (!bus.tx_req && bus.fifo_count == '0 && !bus.msg_active && sb.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
        chk(tag, 32'(ok), 32'd1);
    endtask

    task automatic wait_msg_up(input string tag);
        bit ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(posedge clk); #1;
            if (bus.msg_active) begin
                ok = 1'b1;
                break;
            end
        end
        chk(tag, 32'(ok), 32'd1);
    endtask

    // Transmitter model: checks each new request, answers with tx_done later.
    initial begin : responder
        logic       prev_req;
        int         cnt;
        int         done_ack;
        logic [7:0] e;
        prev_req    = 1'b0;
        cnt         = 0;
        done_ack    = 0;
        bus.tx_done = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                prev_req    = 1'b0;
                cnt         = 0;
                bus.tx_done = 1'b0;
                done_ack    = done_req;
            end else begin
                if (bus.tx_done) begin
                    bus.tx_done = 1'b0;
                end else if (done_req != done_ack) begin
                    done_ack    = done_req;
                    bus.tx_done = 1'b1;
                end else if (auto_done && cnt > 0) begin
                    cnt--;
                    if (cnt == 0) bus.tx_done = 1'b1;
                end
                if (bus.tx_req && !prev_req) begin
                    n_rise++;
                    chk("sb_nonempty", 32'(sb.size() != 0), 32'd1);
                    if (sb.size() != 0) begin
                        e = sb.pop_front();
                        chk("tx_word", 32'(bus.tx_word), 32'(e));
                    end
                    cnt = DONE_DLY;
                end
                prev_req = bus.tx_req;
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        bit s;
        bit found;
        int g;
        int base;
        int rises;

        rom = '{8'h48, 8'h65, 8'h6C, 8'h6C, 8'h6F, 8'h20, 8'h77,
                8'h6F, 8'h72, 8'h6C, 8'h64, 8'h21, 8'h0A};
        n_checks     = 0;
        n_fail       = 0;
        n_rise       = 0;
        done_req     = 0;
        auto_done    = 1'b1;
        rst          = 1'b0;
        bus.sw       = 1'b0;
        bus.rx_word  = 8'h00;
        bus.rx_valid = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_tx_req", 32'(bus.tx_req), 32'd0);
        chk("rst_tx_word", 32'(bus.tx_word), 32'h00);
        chk("rst_msg_active", 32'(bus.msg_active), 32'd0);
        chk("rst_overflow", 32'(bus.overflow), 32'd0);
        chk("rst_fifo_count", 32'(bus.fifo_count), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        repeat (5) @(negedge clk);

        // Single echo byte with edge-exact latency.
        bus.rx_word  = 8'h41;
        bus.rx_valid = 1'b1;
        sb.push_back(8'h41);
        @(posedge clk); #1;
        chk("echo_count_after_push", 32'(bus.fifo_count), 32'd1);
        chk("echo_req_not_yet", 32'(bus.tx_req), 32'd0);
        @(posedge clk); #1;
        chk("echo_req_up", 32'(bus.tx_req), 32'd1);
        chk("echo_word", 32'(bus.tx_word), 32'h41);
        chk("echo_count_popped", 32'(bus.fifo_count), 32'd0);
        @(negedge clk);
        bus.rx_valid = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            s = bus.tx_done;
            #1;
            if (s) begin
                found = 1'b1;
                break;
            end
        end
        chk("echo_done_seen", 32'(found), 32'd1);
        chk("echo_req_drop", 32'(bus.tx_req), 32'd0);
        wait_idle("echo_idle", 50);

        // Full message, then gap timing to the next message.
        @(negedge clk);
        bus.sw = 1'b1;
        push_msg();
        wait_msg_up("msg_active_up");
        found = 1'b0;
        s     = 1'b0;
        for (int i = 0; i < 500; i++) begin
            @(posedge clk);
            s = bus.tx_done;
            #1;
            if (!bus.msg_active) begin
                found = 1'b1;
                break;
            end
        end
        chk("msg_end_seen", 32'(found), 32'd1);
        chk("msg_end_on_done", 32'(s), 32'd1);
        chk("msg_all_bytes", 32'(sb.size()), 32'd0);
        push_msg();
        g = 0;
        for (int i = 0; i < int'(GAP) + 50; i++) begin
            @(posedge clk); #1;
            g++;
            if (bus.tx_req) break;
        end
        chk("gap_cycles", 32'(g), 32'(GAP + 1));
        chk("msg2_active", 32'(bus.msg_active), 32'd1);

        // Echo bytes arriving mid-message queue and drain after the burst.
        base  = n_rise;
        found = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk); #1;
            if (n_rise >= base + 3) begin
                found = 1'b1;
                break;
            end
        end
        chk("msg2_byte3_seen", 32'(found), 32'd1);
        bus.sw = 1'b0;
        rx_send(8'h31, 1'b1);
        rx_send(8'h32, 1'b1);
        chk("mid_msg_queued", 32'(bus.fifo_count), 32'd2);
        chk("mid_msg_active", 32'(bus.msg_active), 32'd1);
        wait_idle("echo_after_msg_idle", 1000);
        rises = n_rise;
        repeat (GAP + 5) @(posedge clk);
        #1;
        chk("no_msg_when_sw0", 32'(n_rise), 32'(rises));

        // Push and pop in the same cycle while full.
        do_reset();
        auto_done = 1'b0;
        for (int i = 1; i <= 5; i++) rx_send(8'(i), 1'b1);
        chk("full_count", 32'(bus.fifo_count), 32'd4);
        chk("full_no_overflow", 32'(bus.overflow), 32'd0);
        chk("full_inflight", 32'(bus.tx_word), 32'h01);
        @(posedge clk); #1;
        done_req++;
        @(posedge clk); #1;
        bus.rx_word  = 8'h06;
        bus.rx_valid = 1'b1;
        sb.push_back(8'h06);
        @(posedge clk); #1;
        chk("simul_count", 32'(bus.fifo_count), 32'd4);
        chk("simul_no_overflow", 32'(bus.overflow), 32'd0);
        chk("simul_req", 32'(bus.tx_req), 32'd1);
        chk("simul_word", 32'(bus.tx_word), 32'h02);
        @(negedge clk);
        bus.rx_valid = 1'b0;
        auto_done    = 1'b1;
        wait_idle("simul_drain_idle", 500);

        // Overflow: transmitter held busy, sixth byte dropped.
        do_reset();
        auto_done = 1'b0;
        for (int i = 1; i <= 6; i++) rx_send(8'(i), i <= 5);
        chk("ovf_count", 32'(bus.fifo_count), 32'd4);
        chk("ovf_flag", 32'(bus.overflow), 32'd1);
        chk("ovf_inflight", 32'(bus.tx_word), 32'h01);
        chk("ovf_req", 32'(bus.tx_req), 32'd1);
        repeat (10) @(posedge clk);
        #1;
        chk("ovf_sticky", 32'(bus.overflow), 32'd1);
        do_reset();
        @(posedge clk); #1;
        chk("ovf_cleared_by_rst", 32'(bus.overflow), 32'd0);
        chk("fifo_empty_after_rst", 32'(bus.fifo_count), 32'd0);

        // Reset during byte 5 of a message; next byte after release is 0x48.
        auto_done = 1'b1;
        @(negedge clk);
        bus.sw = 1'b1;
        push_msg();
        base  = n_rise;
        found = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk); #1;
            if (n_rise >= base + 5) begin
                found = 1'b1;
                break;
            end
        end
        chk("msg_byte5_seen", 32'(found), 32'd1);
        #2;
        rst = 1'b0;
        #1;
        chk("midrst_tx_req", 32'(bus.tx_req), 32'd0);
        chk("midrst_msg_active", 32'(bus.msg_active), 32'd0);
        chk("midrst_tx_word", 32'(bus.tx_word), 32'h00);
        chk("midrst_fifo_count", 32'(bus.fifo_count), 32'd0);
        sb.delete();
        repeat (2) @(negedge clk);
        push_msg();
        rst = 1'b1;
        wait_msg_up("msg_restart_up");
        chk("msg_restart_word", 32'(bus.tx_word), 32'h48);
        @(negedge clk);
        bus.sw = 1'b0;
        wait_idle("msg_restart_idle", 1000);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
